// File: rtl/branch_resolve_pkg.sv
// Shared RISC-V branch decode constants used by the branch resolve stage
// and the BrUn decode.
package branch_resolve_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_funct3_e;

    // funct3 010/011 under the branch opcode are reserved and pass through.
    function automatic logic is_branch_f3(input logic [2:0] f3);
        return (f3 == F3_BEQ)  || (f3 == F3_BNE)  || (f3 == F3_BLT) ||
               (f3 == F3_BGE)  || (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Bundle between the decode stage and the branch resolve stage: operand
// inputs, resolved outputs, redirect/flush and statistics.
interface branch_resolve_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic             in_valid;
    logic [31:0]      in_inst;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_rs1;
    logic [XLEN-1:0]  in_rs2;
    logic             br_un;
    logic             stall;
    logic             out_valid;
    logic             br_eq;
    logic             br_lt;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    modport master (
        output in_valid, in_inst, in_pc, in_rs1, in_rs2, br_un, stall,
        input  out_valid, br_eq, br_lt, redirect, redirect_pc, flush,
               branch_count, taken_count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_rs1, in_rs2, br_un, stall,
        output out_valid, br_eq, br_lt, redirect, redirect_pc, flush,
               branch_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_comp.sv
// Combinational XLEN-wide equality / less-than comparator with an unsigned
// select; also intended for forwarding-compare reuse.
module branch_comp #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            un_i,
    output logic            eq_o,
    output logic            lt_o
);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;

    assign a_s = a_i;
    assign b_s = b_i;

    always_comb begin
        eq_o = (a_i == b_i);
        lt_o = un_i ? (a_i < b_i) : (a_s < b_s);
    end
endmodule

// File: rtl/branch_resolve.sv
// Conditional branch resolution: registered compare, taken decision, PC
// redirect, wrong-path squash window and saturating branch statistics.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input logic             clk,
    input logic             rst,
    branch_resolve_if.slave bus
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {ST_IDLE, ST_SQUASH} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    sq_cnt_q, sq_cnt_d;
    logic             out_valid_q, br_eq_q, br_lt_q, redirect_q;
    logic [XLEN-1:0]  redirect_pc_q;
    logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

    logic [2:0] funct3;
    logic       is_branch, accept, take, cond, cmp_un, cmp_eq, cmp_lt;
    logic [XLEN-1:0] target;

    function automatic logic [XLEN-1:0] b_imm(input logic [31:0] inst);
        return {{(XLEN-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign funct3    = bus.in_inst[14:12];
    assign is_branch = (bus.in_inst[6:0] == OPC_BRANCH) && is_branch_f3(funct3);
    assign accept    = bus.in_valid && !bus.stall && (state_q == ST_IDLE);
    // br_un may be X on non-branches; keep it out of the comparator.
    assign cmp_un    = is_branch & bus.br_un;
    assign target    = bus.in_pc + b_imm(bus.in_inst);

    branch_comp #(.XLEN(XLEN)) u_comp (
        .a_i (bus.in_rs1),
        .b_i (bus.in_rs2),
        .un_i(cmp_un),
        .eq_o(cmp_eq),
        .lt_o(cmp_lt)
    );

    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:           cond = cmp_eq;
            F3_BNE:           cond = !cmp_eq;
            F3_BLT, F3_BLTU:  cond = cmp_lt;
            F3_BGE, F3_BGEU:  cond = !cmp_lt;
            default:          cond = 1'b0;
        endcase
    end

    assign take = accept && is_branch && cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sq_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        if (!bus.stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        state_d  = ST_SQUASH;
                        sq_cnt_d = CW'(FLUSH_CYCLES);
                    end
                end
                ST_SQUASH: begin
                    if (sq_cnt_q == CW'(1)) begin
                        state_d  = ST_IDLE;
                        sq_cnt_d = '0;
                    end else begin
                        sq_cnt_d = sq_cnt_q - CW'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.flush = (state_q == ST_SQUASH);
    end

    // Resolved-instruction stage; everything freezes under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q   <= 1'b0;
            br_eq_q       <= 1'b0;
            br_lt_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            taken_cnt_q   <= '0;
        end else if (!bus.stall) begin
            out_valid_q   <= accept;
            br_eq_q       <= accept && is_branch && cmp_eq;
            br_lt_q       <= accept && is_branch && cmp_lt;
            redirect_q    <= take;
            redirect_pc_q <= take ? target : '0;
            if (accept && is_branch) branch_cnt_q <= sat_inc(branch_cnt_q);
            if (take)                taken_cnt_q  <= sat_inc(taken_cnt_q);
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.br_eq        = br_eq_q;
    assign bus.br_lt        = br_lt_q;
    assign bus.redirect     = redirect_q;
    assign bus.redirect_pc  = redirect_pc_q;
    assign bus.branch_count = branch_cnt_q;
    assign bus.taken_count  = taken_cnt_q;
endmodule
